capture_scheduler: RTL

//  Sequences frame captures across the two imager channels (cam0, cam1) on a programmable period.

---
 rtl/capture_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/capture_scheduler.sv
// capture_scheduler
//   Sequences frame captures across two imager channels (cam0, cam1) on a
//   programmable round period. Each round visits every enabled channel in
//   ascending order. A start is held off while the target FIFO is almost
//   full. A channel that never reports done is recovered by a timeout and a
//   one-cycle channel reset.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   enable            level, run rounds continuously
//   single_shot       pulse, run exactly one round (ignored while busy)
//   cam_enable[1:0]   per-channel participation
//   frame_period      cycles from one round start to the next (0 = back-to-back)
//   err_clear         pulse, clears timeout_err and overrun
//   camN_done         frame_capture_done from channel N
//   camN_fifo_afull   channel N FIFO almost full
//   camN_start        one-cycle frame_capture_start to channel N
//   camN_reset        one-cycle channel reset after a timeout on channel N
//   busy              scheduler is not idle
//   active_cam        currently selected channel
//   frame_count       completed frames on both channels, wrapping
//   timeout_err       sticky, a capture timed out
//   overrun           sticky, a round lasted longer than frame_period
module capture_scheduler #(
    parameter int unsigned          PERIOD_W    = 24,
    parameter int unsigned          TIMEOUT_W   = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = {TIMEOUT_W{1'b1}},
    parameter int unsigned          COUNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                single_shot,
    input  logic [1:0]          cam_enable,
    input  logic [PERIOD_W-1:0] frame_period,
    input  logic                err_clear,
    input  logic                cam0_done,
    input  logic                cam1_done,
    input  logic                cam0_fifo_afull,
    input  logic                cam1_fifo_afull,
    output logic                cam0_start,
    output logic                cam1_start,
    output logic                cam0_reset,
    output logic                cam1_reset,
    output logic                busy,
    output logic                active_cam,
    output logic [COUNT_W-1:0]  frame_count,
    output logic                timeout_err,
    output logic                overrun
);

    typedef enum logic [2:0] {
        IDLE, SELECT, WAIT_FIFO, START, CAPTURE, NEXT, WAIT_PERIOD
    } state_t;

    state_t                state, state_next;
    logic [PERIOD_W-1:0]   period_cnt, period_cnt_inc;
    logic [TIMEOUT_W-1:0]  timeout_cnt;
    logic                  single_round;
    logic                  prev_was_next;
    logic                  sel_afull, sel_done, lowest_cam;
    logic                  round_start, advance_cam, frame_done;
    logic                  capture_timeout, set_overrun;

    assign sel_afull      = active_cam ? cam1_fifo_afull : cam0_fifo_afull;
    assign sel_done       = active_cam ? cam1_done : cam0_done;
    assign lowest_cam     = ~cam_enable[0];
    assign period_cnt_inc = (period_cnt == '1) ? period_cnt : period_cnt + 1'b1;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next      = state;
        round_start     = 1'b0;
        advance_cam     = 1'b0;
        frame_done      = 1'b0;
        capture_timeout = 1'b0;
        set_overrun     = 1'b0;
        case (state)
            IDLE: begin
                if ((enable || single_shot) && cam_enable != '0) begin
                    state_next  = SELECT;
                    round_start = 1'b1;
                end
            end
            SELECT:    state_next = WAIT_FIFO;
            WAIT_FIFO: if (!sel_afull) state_next = START;
            START:     state_next = CAPTURE;
            CAPTURE: begin
                if (sel_done) begin
                    frame_done = 1'b1;
                    state_next = NEXT;
                end else if (timeout_cnt == TIMEOUT_MAX) begin
                    capture_timeout = 1'b1;
                    state_next      = NEXT;
                end
            end
            NEXT: begin
                if (!active_cam && cam_enable[1]) begin
                    advance_cam = 1'b1;
                    state_next  = SELECT;
                end else if (single_round || !enable) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_PERIOD;
                end
            end
            WAIT_PERIOD: begin
                if (!enable || cam_enable == '0) begin
                    state_next = IDLE;
                end else begin
                    // period_cnt is 0 in the round's first cycle, so the
                    // cycles elapsed so far including this one is cnt+1.
                    if (prev_was_next && frame_period != '0 &&
                        period_cnt >= frame_period)
                        set_overrun = 1'b1;
                    if (period_cnt_inc >= frame_period) begin
                        state_next  = SELECT;
                        round_start = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Pulses are suppressed on the reset cycle itself.
        cam0_start = !reset && state == START && !active_cam;
        cam1_start = !reset && state == START &&  active_cam;
        cam0_reset = !reset && capture_timeout && !active_cam;
        cam1_reset = !reset && capture_timeout &&  active_cam;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt    <= '0;
            timeout_cnt   <= '0;
            active_cam    <= 1'b0;
            frame_count   <= '0;
            timeout_err   <= 1'b0;
            overrun       <= 1'b0;
            single_round  <= 1'b0;
            prev_was_next <= 1'b0;
        end else begin
            prev_was_next <= (state == NEXT);

            if (round_start || state == IDLE) period_cnt <= '0;
            else                              period_cnt <= period_cnt_inc;

            if (round_start)      active_cam <= lowest_cam;
            else if (advance_cam) active_cam <= 1'b1;

            if (state == START)        timeout_cnt <= '0;
            else if (state == CAPTURE) timeout_cnt <= timeout_cnt + 1'b1;

            if (frame_done) frame_count <= frame_count + 1'b1;

            if (state == IDLE && round_start) single_round <= !enable;

            if (capture_timeout) timeout_err <= 1'b1;
            else if (err_clear)  timeout_err <= 1'b0;

            if (set_overrun)    overrun <= 1'b1;
            else if (err_clear) overrun <= 1'b0;
        end
    end

endmodule
